// File: rtl/shift_unit_iter.sv
// shift_unit_iter: iterative shifter/rotator that applies one 1-bit step per
// clock. The operand, count and op are latched on an accepted start, so later
// input changes do not affect the operation in flight.
//
// Ports:
//   clock     - single clock; all state updates on the rising edge
//   clear     - synchronous, active-high reset
//   start     - request an operation; sampled only in IDLE
//   op        - 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL (others: no shift)
//   Ra        - operand
//   shift_amt - shift count 0..31
//   busy      - high whenever the unit is not IDLE
//   done      - one-cycle pulse; result is valid
//   result    - final value; held until the next operation completes
module shift_unit_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [4:0]       shift_amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_step;
  logic [4:0]       count;
  logic [2:0]       op_reg;
  logic             op_legal;

  assign op_legal = (op <= OP_ROL);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // One 1-bit step of the latched operation.
  always_comb begin
    work_step = work;
    case (op_reg)
      OP_SHR:  work_step = {1'b0, work[WIDTH-1:1]};
      OP_SHRA: work_step = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_SHL:  work_step = {work[WIDTH-2:0], 1'b0};
      OP_ROR:  work_step = {work[0], work[WIDTH-1:1]};
      OP_ROL:  work_step = {work[WIDTH-2:0], work[WIDTH-1]};
      default: work_step = work;
    endcase
  end

  // result is loaded only on the edge that enters DONE, so intermediate
  // work values never appear on the output.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      op_reg <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work   <= Ra;
            count  <= shift_amt;
            op_reg <= op;
            if ((shift_amt != 5'd0) && op_legal) begin
              state <= SHIFT;
            end else begin
              state  <= DONE;
              result <= Ra;
            end
          end
        end
        SHIFT: begin
          work  <= work_step;
          count <= count - 5'd1;
          if (count == 5'd1) begin
            state  <= DONE;
            result <= work_step;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed testbench for shift_unit_iter: hand-computed results and latencies,
// mid-operation input disturbance, clear abort, and back-to-back starts.
module tb_shift_unit_iter;

  localparam int unsigned WIDTH = 32;

  logic             clock = 1'b0;
  logic             clear;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] Ra;
  logic [4:0]       shift_amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clock = ~clock;

  shift_unit_iter #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .Ra        (Ra),
    .shift_amt (shift_amt),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Launch one operation, scramble the inputs right after the start edge,
  // then wait (bounded) for done and check latency, result and busy.
  task automatic run_op(input string tag, input logic [2:0] op_i,
                        input logic [31:0] ra_i, input logic [4:0] amt_i,
                        input logic [31:0] exp_res, input int exp_lat,
                        input bit disturb);
    logic [31:0] prev;
    int lat;
    bit busy_ok, mid_ok;
    @(negedge clock);
    prev = result;
    op = op_i; Ra = ra_i; shift_amt = amt_i; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; Ra = ~ra_i; op = 3'b010; shift_amt = ~amt_i;
    lat = 0; busy_ok = 1'b1; mid_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (result !== prev) mid_ok = 1'b0;
      if (disturb && lat == 3) begin
        start = 1'b1; Ra = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, result, exp_res);
    if (exp_lat > 0) begin
      check({tag, ".busy"}, 32'(busy_ok), 32'd1);
      check({tag, ".hold"}, 32'(mid_ok), 32'd1);
    end
    @(negedge clock);
    check({tag, ".pulse"}, 32'(done), 32'd0);
    check({tag, ".stable"}, result, exp_res);
  endtask

  initial begin
    int seen;
    int first_idx, second_idx, n_done;

    clear = 1'b1; start = 1'b0; op = '0; Ra = '0; shift_amt = '0;
    repeat (2) @(negedge clock);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", result, 32'd0);
    clear = 1'b0;

    run_op("shra_neg10", 3'b001, 32'hFFFFFFF6, 5'd4,  32'hFFFFFFFF, 4,  1'b0);
    run_op("shra_pos",   3'b001, 32'h7FFFFFFF, 5'd4,  32'h07FFFFFF, 4,  1'b0);
    run_op("shr_31",     3'b000, 32'h80000000, 5'd31, 32'h00000001, 31, 1'b0);
    run_op("shl_0",      3'b010, 32'h12345678, 5'd0,  32'h12345678, 0,  1'b0);
    run_op("illegal7",   3'b111, 32'h12345678, 5'd5,  32'h12345678, 0,  1'b0);
    run_op("illegal5",   3'b101, 32'hABCD0123, 5'd3,  32'hABCD0123, 0,  1'b0);
    run_op("rol_1",      3'b100, 32'h80000001, 5'd1,  32'h00000003, 1,  1'b0);
    run_op("ror_31",     3'b011, 32'h00000001, 5'd31, 32'h00000002, 31, 1'b0);
    run_op("rol_4",      3'b100, 32'h12345678, 5'd4,  32'h23456781, 4,  1'b0);
    run_op("shr_4",      3'b000, 32'hF0000000, 5'd4,  32'h0F000000, 4,  1'b0);
    run_op("shl_31",     3'b010, 32'h00000001, 5'd31, 32'h80000000, 31, 1'b0);
    run_op("shra_min",   3'b001, 32'h80000000, 5'd31, 32'hFFFFFFFF, 31, 1'b0);
    run_op("shra_dist",  3'b001, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF, 31, 1'b1);
    repeat (3) @(negedge clock);
    check("shra_dist.after", result, 32'hFFFFFFFF);

    // Clear three cycles after start aborts the operation with no done.
    @(negedge clock);
    op = 3'b000; Ra = 32'hFFFF0000; shift_amt = 5'd20; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    check("clear.busy", 32'(busy), 32'd0);
    check("clear.done", 32'(done), 32'd0);
    check("clear.result", result, 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    check("clear.no_done", 32'(seen), 32'd0);
    run_op("after_clear", 3'b010, 32'h00000001, 5'd2, 32'h00000004, 2, 1'b0);

    // start held high: done after edges 2, 6, 10 (one start per N+2 cycles).
    @(negedge clock);
    op = 3'b010; Ra = 32'h00000001; shift_amt = 5'd2; start = 1'b1;
    first_idx = -1; second_idx = -1; n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        if (n_done == 0) first_idx = i;
        else if (n_done == 1) second_idx = i;
        n_done++;
      end
    end
    start = 1'b0;
    check("held.first", 32'(first_idx), 32'd2);
    check("held.second", 32'(second_idx), 32'd6);
    check("held.count", 32'(n_done), 32'd3);
    check("held.result", result, 32'h00000004);
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
